// File: rtl/evict_ds_serializer_if.sv
// Payload types and the handshake interface for evict_ds_serializer.
//
// evict_ds_pkg      : widths and packed payload structs shared by the serializer and its peers.
// evict_ds_serializer_if: groups the block input, beat output and completion signals.
//   slave  modport : serializer view (consumes in_*, out_rdy; drives the rest)
//   master modport : environment view (drives in_*, out_rdy; observes the rest)

package evict_ds_pkg;

  localparam int unsigned BUS_WIDTH            = 128;
  localparam int unsigned BLK_WIDTH            = 1024;
  localparam int unsigned MSHR_ENTRY_IDX_WIDTH = 4;
  localparam int unsigned DB_ENTRY_IDX_WIDTH   = 3;
  localparam int unsigned TXNID_WIDTH          = 8;
  localparam int unsigned SIDEBAND_WIDTH       = 4;
  localparam int unsigned TAG_WIDTH            = 23;
  localparam int unsigned INDEX_WIDTH          = 8;
  localparam int unsigned OFFSET_WIDTH         = 9;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  typedef struct packed {
    addr_t                           addr;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } arb_out_req_t;

  typedef struct packed {
    logic [BLK_WIDTH-1:0] data;
    arb_out_req_t         evict_req_pld;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0]            data;
    addr_t                           addr;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
    logic                            last;
  } evict_to_ds_pld_t;

endpackage

interface evict_ds_serializer_if;

  logic                                          in_vld;
  logic                                          in_rdy;
  evict_ds_pkg::ram_to_evdb_pld_t                in_pld;
  logic                                          out_vld;
  logic                                          out_rdy;
  evict_ds_pkg::evict_to_ds_pld_t                out_pld;
  logic                                          done_vld;
  logic [evict_ds_pkg::MSHR_ENTRY_IDX_WIDTH-1:0] done_rob_id;
  logic                                          busy;

  modport slave (
    input  in_vld, in_pld, out_rdy,
    output in_rdy, out_vld, out_pld, done_vld, done_rob_id, busy
  );

  modport master (
    output in_vld, in_pld, out_rdy,
    input  in_rdy, out_vld, out_pld, done_vld, done_rob_id, busy
  );

endinterface

// File: rtl/evict_ds_serializer.sv
// Serializes whole evicted data blocks into BEATS downstream beats, LS slice first.
//
// Ports:
//   clk  : sole clock
//   rst  : asynchronous active-high reset
//   bus  : evict_ds_serializer_if.slave
//          in_vld/in_rdy/in_pld     block input (in_rdy = count < DEPTH, registered)
//          out_vld/out_rdy/out_pld  beat output, decoded from FIFO head and beat counter
//          done_vld/done_rob_id     one-cycle completion pulse after a block's last beat
//          busy                     FIFO non-empty

module evict_ds_serializer #(
  parameter int unsigned DATA_W = evict_ds_pkg::BLK_WIDTH,
  parameter int unsigned BUS_W  = evict_ds_pkg::BUS_WIDTH,
  parameter int unsigned BEATS  = DATA_W / BUS_W,
  parameter int unsigned DEPTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  evict_ds_serializer_if.slave bus
);

  import evict_ds_pkg::*;

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_STEP = BUS_W / 8;

  typedef logic [PTR_W-1:0] ptr_t;

  ram_to_evdb_pld_t                mem_q [DEPTH];
  ram_to_evdb_pld_t                mem_d [DEPTH];
  ptr_t                            wr_ptr_q, wr_ptr_d;
  ptr_t                            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic                            done_vld_q, done_vld_d;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_rob_id_q, done_rob_id_d;

  ram_to_evdb_pld_t        head;
  logic [DATA_W-1:0]       head_data;
  logic [OFFSET_WIDTH-1:0] beat_off;
  evict_to_ds_pld_t        out_pld;
  logic                    in_rdy, out_vld, last_beat;
  logic                    push, pop_beat, pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_data = head.data;
    in_rdy    = count_q < CNT_W'(DEPTH);
    out_vld   = count_q != '0;
    last_beat = beat_q == BEAT_W'(BEATS - 1);

    // in_rdy uses the pre-pop count, so a slot freed this cycle is never refilled this cycle.
    push     = bus.in_vld && in_rdy;
    pop_beat = out_vld && bus.out_rdy;
    pop      = pop_beat && last_beat;

    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    beat_d        = beat_q;
    done_vld_d    = pop;
    done_rob_id_d = done_rob_id_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.in_pld;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (pop_beat) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d      = ptr_inc(rd_ptr_q);
      done_rob_id_d = head.evict_req_pld.rob_entry_id;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Offset add deliberately wraps within the OFFSET_WIDTH field; tag/index are untouched.
    beat_off = OFFSET_WIDTH'(32'(beat_q) * OFF_STEP);

    out_pld.data         = head_data[32'(beat_q) * BUS_W +: BUS_W];
    out_pld.addr.tag     = head.evict_req_pld.addr.tag;
    out_pld.addr.index   = head.evict_req_pld.addr.index;
    out_pld.addr.offset  = head.evict_req_pld.addr.offset + beat_off;
    out_pld.rob_entry_id = head.evict_req_pld.rob_entry_id;
    out_pld.db_entry_id  = head.evict_req_pld.db_entry_id;
    out_pld.txnid        = head.evict_req_pld.txnid;
    out_pld.sideband     = head.evict_req_pld.sideband;
    out_pld.last         = last_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      done_vld_q    <= 1'b0;
      done_rob_id_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      done_vld_q    <= done_vld_d;
      done_rob_id_q <= done_rob_id_d;
    end
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.out_vld     = out_vld;
  assign bus.out_pld     = out_pld;
  assign bus.busy        = out_vld;
  assign bus.done_vld    = done_vld_q;
  assign bus.done_rob_id = done_rob_id_q;

endmodule

// File: tb/tb_evict_ds_serializer.sv
// Bench for evict_ds_serializer: queue-based block model checked every cycle on the falling
// edge, plus directed scenarios with literal expectations.

module tb_evict_ds_serializer;

  import evict_ds_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned BEATS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  evict_ds_serializer_if bus ();

  evict_ds_serializer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  ram_to_evdb_pld_t mq[$];
  int               mbeat = 0;
  bit               exp_done = 0;
  logic [3:0]       exp_done_id = '0;

  evict_to_ds_pld_t cap[$];
  int               cap_cyc[$];
  int               done_cyc[$];
  logic [3:0]       done_ids[$];

  function automatic evict_to_ds_pld_t model_beat(input ram_to_evdb_pld_t b, input int k);
    evict_to_ds_pld_t r;
    logic [1023:0]    sh;
    sh                = b.data >> (k * 128);
    r.data            = sh[127:0];
    r.addr.tag        = b.evict_req_pld.addr.tag;
    r.addr.index      = b.evict_req_pld.addr.index;
    r.addr.offset     = 9'((int'(b.evict_req_pld.addr.offset) + k * 16) % 512);
    r.rob_entry_id    = b.evict_req_pld.rob_entry_id;
    r.db_entry_id     = b.evict_req_pld.db_entry_id;
    r.txnid           = b.evict_req_pld.txnid;
    r.sideband        = b.evict_req_pld.sideband;
    r.last            = (k == BEATS - 1);
    return r;
  endfunction

  always @(negedge clk) begin
    bit do_push;
    bit do_beat;
    if (rst) begin
      mq.delete();
      mbeat    = 0;
      exp_done = 0;
      check("rst_in_rdy", bus.in_rdy, 1);
      check("rst_out_vld", bus.out_vld, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done_vld", bus.done_vld, 0);
    end else begin
      check("in_rdy", bus.in_rdy, mq.size() < DEPTH);
      check("out_vld", bus.out_vld, mq.size() != 0);
      check("busy", bus.busy, mq.size() != 0);
      check("done_vld", bus.done_vld, exp_done);
      if (exp_done) check("done_rob_id", bus.done_rob_id, exp_done_id);
      if (mq.size() != 0) check("out_pld", bus.out_pld, model_beat(mq[0], mbeat));

      if (bus.out_vld && bus.out_rdy) begin
        cap.push_back(bus.out_pld);
        cap_cyc.push_back(cyc);
      end
      if (bus.done_vld) begin
        done_cyc.push_back(cyc);
        done_ids.push_back(bus.done_rob_id);
      end

      do_push  = bus.in_vld && (mq.size() < DEPTH);
      do_beat  = (mq.size() != 0) && bus.out_rdy;
      exp_done = 0;
      if (do_beat) begin
        if (mbeat == BEATS - 1) begin
          exp_done    = 1;
          exp_done_id = mq[0].evict_req_pld.rob_entry_id;
          void'(mq.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (do_push) mq.push_back(bus.in_pld);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic ram_to_evdb_pld_t make_blk(input int seed, input logic [8:0] off,
                                                input logic [3:0] rob);
    ram_to_evdb_pld_t b;
    for (int k = 0; k < BEATS; k++) b.data[k*128 +: 128] = {16{8'(k + seed)}};
    b.evict_req_pld.addr.tag     = 23'h5A5A5 ^ 23'(seed);
    b.evict_req_pld.addr.index   = 8'(seed * 3 + 1);
    b.evict_req_pld.addr.offset  = off;
    b.evict_req_pld.rob_entry_id = rob;
    b.evict_req_pld.db_entry_id  = 3'(seed);
    b.evict_req_pld.txnid        = 8'(seed + 64);
    b.evict_req_pld.sideband     = 4'(seed);
    return b;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the block.
  task automatic push_blk(input ram_to_evdb_pld_t b, output int acc);
    bus.in_vld = 1'b1;
    bus.in_pld = b;
    acc        = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got no accept, expected accept within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic clear_caps();
    cap.delete();
    cap_cyc.delete();
    done_cyc.delete();
    done_ids.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    ram_to_evdb_pld_t b, a_blk, b_blk, c_blk, d_blk, e_blk;
    int acc, b_acc, c_acc, e_acc;
    logic [8:0] offs1 [8];
    logic [8:0] offs2 [8];
    logic [8:0] offs3 [8];

    offs1 = '{9'h000, 9'h010, 9'h020, 9'h030, 9'h040, 9'h050, 9'h060, 9'h070};
    offs2 = '{9'h1F0, 9'h000, 9'h010, 9'h020, 9'h030, 9'h040, 9'h050, 9'h060};
    offs3 = '{9'h040, 9'h050, 9'h060, 9'h070, 9'h080, 9'h090, 9'h0A0, 9'h0B0};

    bus.in_vld  = 1'b0;
    bus.in_pld  = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_rdy", bus.in_rdy, 1);
    check("reset_out_vld", bus.out_vld, 0);
    check("reset_out_pld", bus.out_pld, 0);
    check("reset_done_vld", bus.done_vld, 0);
    check("reset_done_rob_id", bus.done_rob_id, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;

    // Single block, out_rdy high.
    bus.out_rdy = 1'b1;
    clear_caps();
    b = make_blk(0, 9'h000, 4'd5);
    push_blk(b, acc);
    repeat (12) @(posedge clk);
    #1;
    check("t1_nbeats", cap.size(), 8);
    for (int k = 0; k < cap.size() && k < 8; k++) begin
      check("t1_offset", cap[k].addr.offset, offs1[k]);
      check("t1_data", cap[k].data, {16{k[7:0]}});
      check("t1_last", cap[k].last, k == 7);
    end
    if (cap.size() == 8) begin
      check("t1_first_beat_cyc", cap_cyc[0], acc + 1);
      check("t1_last_beat_cyc", cap_cyc[7], acc + 8);
    end
    check("t1_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) begin
      check("t1_done_cyc", done_cyc[0], acc + 9);
      check("t1_done_id", done_ids[0], 4'd5);
    end

    // Offset wrap.
    clear_caps();
    b = make_blk(1, 9'h1F0, 4'd3);
    push_blk(b, acc);
    repeat (12) @(posedge clk);
    #1;
    check("t2_nbeats", cap.size(), 8);
    for (int k = 0; k < cap.size() && k < 8; k++) begin
      check("t2_offset", cap[k].addr.offset, offs2[k]);
      check("t2_tag", cap[k].addr.tag, 23'h5A5A4);
      check("t2_index", cap[k].addr.index, 8'd4);
    end

    // Backpressure 1,0,0 pattern.
    clear_caps();
    b = make_blk(2, 9'h040, 4'd7);
    fork
      push_blk(b, acc);
      begin
        for (int i = 0; i < 40; i++) begin
          bus.out_rdy = (i % 3 == 0);
          @(posedge clk);
          #1;
        end
        bus.out_rdy = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("t3_nbeats", cap.size(), 8);
    for (int k = 0; k < cap.size() && k < 8; k++) begin
      check("t3_offset", cap[k].addr.offset, offs3[k]);
      check("t3_data", cap[k].data, {16{8'(k + 2)}});
      check("t3_last", cap[k].last, k == 7);
    end
    check("t3_ndone", done_cyc.size(), 1);

    // Full FIFO, then release.
    clear_caps();
    bus.out_rdy = 1'b0;
    a_blk = make_blk(3, 9'h100, 4'd1);
    b_blk = make_blk(4, 9'h080, 4'd2);
    c_blk = make_blk(5, 9'h000, 4'd4);
    push_blk(a_blk, acc);
    push_blk(b_blk, b_acc);
    fork
      push_blk(c_blk, c_acc);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t4_full_in_rdy", bus.in_rdy, 0);
        end
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    #1;
    check("t4_nbeats", cap.size(), 24);
    if (cap.size() == 24) begin
      for (int i = 1; i < 24; i++) check("t4_no_bubble", cap_cyc[i], cap_cyc[0] + i);
      check("t4_in_rdy_rise", c_acc, cap_cyc[7] + 1);
      check("t4_order_a", cap[0].rob_entry_id, 4'd1);
      check("t4_order_b", cap[8].rob_entry_id, 4'd2);
      check("t4_order_c", cap[16].rob_entry_id, 4'd4);
    end
    check("t4_ndone", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("t4_done_id_a", done_ids[0], 4'd1);
      check("t4_done_id_b", done_ids[1], 4'd2);
      check("t4_done_id_c", done_ids[2], 4'd4);
    end

    // Push coinciding with last-beat pop at count 1.
    clear_caps();
    d_blk = make_blk(6, 9'h020, 4'd9);
    e_blk = make_blk(7, 9'h1C0, 4'd10);
    push_blk(d_blk, acc);
    repeat (7) @(posedge clk);
    #1;
    push_blk(e_blk, e_acc);
    @(negedge clk);
    check("t5_in_rdy_after", bus.in_rdy, 1);
    check("t5_out_vld_after", bus.out_vld, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t5_accept_cyc", e_acc, acc + 8);
    check("t5_nbeats", cap.size(), 16);
    if (cap.size() == 16) begin
      check("t5_same_cycle", cap_cyc[7], e_acc);
      check("t5_next_beat0_cyc", cap_cyc[8], e_acc + 1);
      check("t5_next_beat0_off", cap[8].addr.offset, 9'h1C0);
      check("t5_next_beat0_data", cap[8].data, {16{8'd7}});
    end

    // Reset during beat 3.
    clear_caps();
    b = make_blk(8, 9'h000, 4'd11);
    push_blk(b, acc);
    repeat (3) @(posedge clk);
    #2;
    check("t6_beats_before_rst", cap.size(), 3);
    check("t6_beat3_off", bus.out_pld.addr.offset, 9'h030);
    rst = 1'b1;
    #1;
    check("t6_rst_in_rdy", bus.in_rdy, 1);
    check("t6_rst_out_vld", bus.out_vld, 0);
    check("t6_rst_out_pld", bus.out_pld, 0);
    check("t6_rst_done_vld", bus.done_vld, 0);
    check("t6_rst_done_rob_id", bus.done_rob_id, 0);
    check("t6_rst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_done", done_cyc.size(), 0);
    clear_caps();
    b = make_blk(9, 9'h0A0, 4'd12);
    push_blk(b, acc);
    repeat (12) @(posedge clk);
    #1;
    check("t6_fresh_nbeats", cap.size(), 8);
    if (cap.size() == 8) begin
      check("t6_fresh_off0", cap[0].addr.offset, 9'h0A0);
      check("t6_fresh_data0", cap[0].data, {16{8'd9}});
      check("t6_fresh_cyc0", cap_cyc[0], acc + 1);
    end
    check("t6_fresh_ndone", done_ids.size(), 1);
    if (done_ids.size() == 1) check("t6_fresh_done_id", done_ids[0], 4'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/evict_ds_serializer.md
# evict_ds_serializer

Sits between the eviction data buffer (EVDB) and the downstream write channel. It accepts whole 1024-bit evicted data blocks as `ram_to_evdb_pld_t` and emits them as 8 consecutive `BUS_WIDTH`-bit beats of `evict_to_ds_pld_t`, least-significant slice first, with `last` on the final beat. A 2-entry payload FIFO decouples SRAM read-out from downstream backpressure. A one-cycle completion pulse returns the ROB entry id to the MSHR/ROB once a block is fully sent.

## Interface
Parameters:
- `DATA_W`, 1024, width of the input data block.
- `BUS_W`, `BUS_WIDTH` (128), downstream beat width.
- `BEATS`, `DATA_W/BUS_W` (8), beats per block.
- `DEPTH`, 2, payload FIFO entries (power of 2, ≥1).

Ports:
- `clk`, in, 1, sole clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `in_vld`, in, 1, input block valid.
- `in_rdy`, out, 1, input ready; equals `count < DEPTH` (registered count, no combinational path from outputs).
- `in_pld`, in, `ram_to_evdb_pld_t`, block data plus `evict_req_pld` (`arb_out_req_t`).
- `out_vld`, out, 1, downstream beat valid.
- `out_rdy`, in, 1, downstream ready.
- `out_pld`, out, `evict_to_ds_pld_t`, beat payload.
- `done_vld`, out, 1, one-cycle pulse when a block's last beat handshakes.
- `done_rob_id`, out, `MSHR_ENTRY_IDX_WIDTH`, ROB entry id of the completed block.
- `busy`, out, 1, `count != 0`.

## Operation
- Storage: `DEPTH`-entry circular FIFO holding the full `in_pld`, plus `wr_ptr`, `rd_ptr` and `count` (`$clog2(DEPTH)+1` bits). Beat counter `beat` is 3 bits.
- Push: `in_vld && in_rdy` writes at `wr_ptr`; `wr_ptr` increments modulo `DEPTH`.
- `out_vld = (count != 0)`. `out_pld` is decoded combinationally from the head entry and `beat`:
  - `data` = `head.data[beat*BUS_W +: BUS_W]`.
  - `addr` = {`tag`, `index`, `offset + beat*(BUS_W/8)`}, with the offset add truncated to `OFFSET_WIDTH` (wraps mod 512).
  - `rob_entry_id`, `db_entry_id`, `txnid`, `sideband` copied from `head.evict_req_pld`.
  - `last` = (`beat == BEATS-1`).
- On `out_vld && out_rdy`:
  - Not last beat: `beat` increments.
  - Last beat: `beat` clears to 0, `rd_ptr` increments, head is popped, and `done_vld`/`done_rob_id` are registered for the next cycle.
- Simultaneous push and pop: `count` stays unchanged. A push is never accepted into a slot freed in the same cycle, because `in_rdy` uses the pre-pop count.
- Full FIFO: `in_rdy = 0`. Empty FIFO: `out_vld = 0` and `beat` holds at 0.
- AXI-style handshake: once `out_vld` is asserted, `out_pld` stays stable until the handshake. `out_vld` never drops without a handshake except on reset.
- Reset (async, at any time, including mid-block): `count`, pointers and `beat` clear to 0, and FIFO contents are discarded. Upstream must not assert `in_vld` during reset.

## Timing
- Reset values: `in_rdy = 1`, `out_vld = 0`, `out_pld = 0` (decoded from zeroed storage), `done_vld = 0`, `done_rob_id = 0`, `busy = 0`.
- Latency: block accepted at cycle N → first beat `out_vld` at N+1.
- With `out_rdy` held high: beats at cycles N+1..N+8, `last` at N+8, `done_vld` at N+9.
- Throughput: 1 beat per cycle, back-to-back blocks with no bubble between `last` and the next block's beat 0.
- `done_vld` is high for exactly one cycle per block, in the cycle after the last-beat handshake.

## Test plan
- Single block, `out_rdy` = 1. Input has `offset` = 0x000 and `data` beat k = {16{k[7:0]}}. Expect:
  - 8 beats with offsets 0x00, 0x10, …, 0x70.
  - Data slices match, `last` only on beat 7.
  - `done_vld` at N+9 with `done_rob_id` = input `rob_entry_id`.
- Offset wrap: `offset` = 0x1F0. Expect beat offsets 0x1F0, 0x000, 0x010, …, 0x060, with `tag`/`index` unchanged.
- Backpressure: `out_rdy` toggles 1,0,0,1,… Expect `out_pld` stable while stalled, all 8 beats delivered in order, and no duplicated or skipped beats.
- Full FIFO: hold `out_rdy` = 0 and push 3 blocks. Expect `in_rdy` = 0 after 2 accepts and the 3rd held. Release `out_rdy`; expect:
  - `in_rdy` rises the cycle after block A's last beat.
  - Blocks A, B, C are emitted back-to-back, 24 beats with no bubbles.
  - Three `done_vld` pulses.
- Simultaneous push/pop: count = 1 and a last-beat handshake coincides with a push. Expect count stays 1 and the next block's beat 0 appears the following cycle.
- Reset mid-block: assert `rst` during beat 3. Expect outputs at reset values asynchronously, no `done_vld`, and a fresh block afterwards starting at beat 0.
